dm_prefetch_scheduler: RTL and testbench
========================================

Name: dm_prefetch_scheduler

Overview:
- Walks the trace repository from a head pointer and issues line prefetches to the direct-mapped cache ahead of the core.
- Keeps one tracker entry per cache set (occupied, mem_addr, processing, trace_index) so that two trace entries never contend for the same set.
- Throttles itself against the core's retire stream using a bounded lookahead window.
- Sits between the trace repository read port, the cache prefetch port and the core retire monitor.

Parameters:
TRACE_ENTRIES, 65536, trace repository depth; index width IW = clog2(TRACE_ENTRIES)
DATA_ADDR_WIDTH, 32, byte address width
INSTR_DATA_WIDTH, 32, instruction width
NUM_SETS, 64, cache sets; SW = clog2(NUM_SETS)
LINE_OFFSET_BITS, 4, byte-offset bits per line
LOOKAHEAD, 16, max trace entries scheduled beyond last retired index (1..2^IW-1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
trace_wr_ptr  in  IW  next index the repository will write; entries before it are valid
trace_rd_req  out  1  trace read request
trace_rd_index  out  IW  index being read
trace_rd_valid  in  1  read data valid (one-cycle pulse)
trace_rd_data  in  INSTR_DATA_WIDTH+DATA_ADDR_WIDTH  {instruction, mem_addr}
pf_req  out  1  prefetch request
pf_addr  out  DATA_ADDR_WIDTH  line-aligned prefetch address
pf_gnt  in  1  prefetch accepted
pf_done  in  1  prefetch fill complete (pulse)
pf_done_set  in  SW  set index of completed fill
retire_valid  in  1  core completed a traced memory access
retire_index  in  IW  trace index of that access
retire_addr  in  DATA_ADDR_WIDTH  address of that access
head_index  out  IW  next trace index to schedule
busy  out  1  state != IDLE

Behaviour:
- Address decomposition: set = addr[LINE_OFFSET_BITS+SW-1:LINE_OFFSET_BITS]; line = addr with the low LINE_OFFSET_BITS bits cleared. Tags compare line addresses.
- Reset: all outputs 0, head_index=0, tail (last retired + 1) = 0, all trackers cleared, state IDLE.
- Window: schedulable iff head != trace_wr_ptr AND (head - tail) mod 2^IW < LOOKAHEAD. head wraps 2^IW-1 -> 0.
- State machine:
  - IDLE: go to READ when schedulable.
  - READ: assert trace_rd_req, trace_rd_index=head. Hold both until trace_rd_valid. Latch data, then go to EVALUATE.
  - EVALUATE: decide using the registered tracker state.
    - Opcode instr[6:0] is neither 7'h03 (load) nor 7'h23 (store): head++, go to IDLE.
    - Tracker[set] free: go to MAKE_REQUEST.
    - Occupied with the same line (merge): set trace_index=head, head++, go to IDLE. No request is issued.
    - Occupied with a different line: go to BLOCKED.
  - MAKE_REQUEST: assert pf_req with pf_addr=line. Hold both stable until pf_gnt. On pf_gnt, in the same cycle:
    - tracker[set] := {occupied=1, mem_addr=line, processing=1, trace_index=head};
    - head++, deassert pf_req, go to IDLE.
  - BLOCKED: re-evaluate every cycle against registered state. When tracker[set] is cleared, go to MAKE_REQUEST the next cycle.
- pf_done: clears processing of tracker[pf_done_set]. Ignored if that entry is not occupied or not processing.
- retire_valid: tail := retire_index+1. Clear tracker[set(retire_addr)] only if it is occupied and its trace_index == retire_index; otherwise no tracker change. Accepted in any state.
- Simultaneous events:
  - pf_done and retire on the same set in the same cycle: both apply, and the entry ends fully cleared.
  - pf_gnt and retire on the same set in the same cycle: the grant write wins.
  - Retire of a still-processing entry clears it; a later pf_done for that set is ignored.
- Mid-operation reset: aborts any outstanding request immediately. All outputs drop to 0 asynchronously.
- A conflicting entry stalls the head; the scheduler never reorders.

Test Plan:
- Reset, then trace_wr_ptr=3 with entries {lw, 0x1000}, {add, 0}, {sw, 0x2014} -> pf_addr 0x1000 then 0x2010, index 1 skipped, head_index=3, busy falls to 0.
- Entries {lw, 0x1000}, {lw, 0x1008} -> exactly one pf_req (0x1000); tracker[0].trace_index=1; retire (0, 0x1000) leaves tracker occupied; retire (1, 0x1008) clears it.
- Entries {lw, 0x1000}, {lw, 0x1400}, both set 0 -> second entry BLOCKED with no pf_req; retire (0, 0x1000) -> pf_req 0x1400 issued within 2 cycles.
- LOOKAHEAD=2, ten load entries, no retires -> exactly 2 grants and head_index=2; one retire_index=0 -> third request issued.
- pf_gnt held low 5 cycles -> pf_req and pf_addr stable throughout; pf_done and retire on the same set in one cycle -> tracker cleared.
- head_index=65535 with trace_wr_ptr=1 -> entries 65535 and 0 scheduled, head wraps to 1; assert rst_n=0 while pf_req=1 -> pf_req=0 immediately, head_index=0.

Source files
------------

// File: rtl/dm_prefetch_scheduler_if.sv
// Purpose : bundles the trace-read, prefetch and retire-monitor signals of dm_prefetch_scheduler.
// Latency : n/a (wiring only).
// Backpressure: trace reads wait for trace_rd_valid; prefetches wait for pf_gnt.
// Ports   : master = scheduler side, slave = environment (trace repo, cache, core).
interface dm_prefetch_scheduler_if #(
  parameter int TRACE_ENTRIES    = 65536,
  parameter int DATA_ADDR_WIDTH  = 32,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int NUM_SETS         = 64
);
  localparam int IW = $clog2(TRACE_ENTRIES);
  localparam int SW = $clog2(NUM_SETS);

  logic [IW-1:0]                              trace_wr_ptr;
  logic                                       trace_rd_req;
  logic [IW-1:0]                              trace_rd_index;
  logic                                       trace_rd_valid;
  logic [INSTR_DATA_WIDTH+DATA_ADDR_WIDTH-1:0] trace_rd_data;
  logic                                       pf_req;
  logic [DATA_ADDR_WIDTH-1:0]                 pf_addr;
  logic                                       pf_gnt;
  logic                                       pf_done;
  logic [SW-1:0]                              pf_done_set;
  logic                                       retire_valid;
  logic [IW-1:0]                              retire_index;
  logic [DATA_ADDR_WIDTH-1:0]                 retire_addr;
  logic [IW-1:0]                              head_index;
  logic                                       busy;

  modport master (
    input  trace_wr_ptr, trace_rd_valid, trace_rd_data,
    input  pf_gnt, pf_done, pf_done_set,
    input  retire_valid, retire_index, retire_addr,
    output trace_rd_req, trace_rd_index, pf_req, pf_addr, head_index, busy
  );

  modport slave (
    output trace_wr_ptr, trace_rd_valid, trace_rd_data,
    output pf_gnt, pf_done, pf_done_set,
    output retire_valid, retire_index, retire_addr,
    input  trace_rd_req, trace_rd_index, pf_req, pf_addr, head_index, busy
  );
endinterface

// File: rtl/dm_prefetch_scheduler.sv
// Purpose : walks the trace from head_index and issues line prefetches, one tracker per cache set.
// Latency : >=3 cycles per trace entry (read, evaluate, request); all outputs registered.
// Backpressure: holds trace_rd_req until trace_rd_valid and pf_req/pf_addr until pf_gnt; stalls on window or set conflict.
// Ports   : clk, rst_n (async active-low), bus (master modport of dm_prefetch_scheduler_if).
module dm_prefetch_scheduler #(
  parameter int TRACE_ENTRIES    = 65536,
  parameter int DATA_ADDR_WIDTH  = 32,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int NUM_SETS         = 64,
  parameter int LINE_OFFSET_BITS = 4,
  parameter int LOOKAHEAD        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dm_prefetch_scheduler_if.master bus
);
  localparam int IW = $clog2(TRACE_ENTRIES);
  localparam int SW = $clog2(NUM_SETS);
  localparam int AW = DATA_ADDR_WIDTH;
  localparam int LO = LINE_OFFSET_BITS;
  localparam logic [IW:0] LOOKAHEAD_W = (IW+1)'(LOOKAHEAD);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_MAKE_REQ, S_BLOCKED} state_t;

  state_t        state;
  logic [IW-1:0] head;
  logic [IW-1:0] tail;          // last retired index + 1
  logic [6:0]    opcode_q;
  logic [AW-1:0] line_q;
  logic          rd_req_q;
  logic [IW-1:0] rd_index_q;
  logic          pf_req_q;
  logic [AW-1:0] pf_addr_q;
  logic          busy_q;

  // Per-set tracker
  logic          trk_occ  [NUM_SETS];
  logic          trk_proc [NUM_SETS];
  logic [AW-1:0] trk_line [NUM_SETS];
  logic [IW-1:0] trk_idx  [NUM_SETS];

  logic [IW-1:0] window_used;
  logic          schedulable;
  logic [SW-1:0] cur_set;
  logic [SW-1:0] ret_set;
  logic [AW-1:0] rd_line;
  logic          is_mem;
  logic [IW-1:0] head_nxt;
  logic          unused_bits;

  // Modular distance works across the head wrap as long as LOOKAHEAD < 2^IW.
  assign window_used = head - tail;
  assign schedulable = (head != bus.trace_wr_ptr) && ({1'b0, window_used} < LOOKAHEAD_W);
  assign cur_set     = line_q[LO+SW-1:LO];
  assign ret_set     = bus.retire_addr[LO+SW-1:LO];
  assign rd_line     = {bus.trace_rd_data[AW-1:LO], {LO{1'b0}}};
  assign is_mem      = (opcode_q == 7'h03) || (opcode_q == 7'h23);
  assign head_nxt    = head + 1'b1;
  assign unused_bits = ^{bus.trace_rd_data[AW+INSTR_DATA_WIDTH-1:AW+7], bus.trace_rd_data[LO-1:0],
                         bus.retire_addr[AW-1:LO+SW], bus.retire_addr[LO-1:0]};

  assign bus.trace_rd_req   = rd_req_q;
  assign bus.trace_rd_index = rd_index_q;
  assign bus.pf_req         = pf_req_q;
  assign bus.pf_addr        = pf_addr_q;
  assign bus.head_index     = head;
  assign bus.busy           = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      head       <= '0;
      tail       <= '0;
      opcode_q   <= '0;
      line_q     <= '0;
      rd_req_q   <= 1'b0;
      rd_index_q <= '0;
      pf_req_q   <= 1'b0;
      pf_addr_q  <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NUM_SETS; i++) begin
        trk_occ[i]  <= 1'b0;
        trk_proc[i] <= 1'b0;
        trk_line[i] <= '0;
        trk_idx[i]  <= '0;
      end
    end else begin
      // Fill completion only drops the processing flag; the entry stays until retired.
      if (bus.pf_done && trk_occ[bus.pf_done_set] && trk_proc[bus.pf_done_set])
        trk_proc[bus.pf_done_set] <= 1'b0;

      // Only the retire of the most recent trace entry mapped to the set frees it.
      if (bus.retire_valid) begin
        tail <= bus.retire_index + 1'b1;
        if (trk_occ[ret_set] && (trk_idx[ret_set] == bus.retire_index)) begin
          trk_occ[ret_set]  <= 1'b0;
          trk_proc[ret_set] <= 1'b0;
        end
      end

      // FSM tracker writes come after the event updates so a grant wins a same-set retire.
      case (state)
        S_IDLE: begin
          if (schedulable) begin
            state      <= S_READ;
            rd_req_q   <= 1'b1;
            rd_index_q <= head;
            busy_q     <= 1'b1;
          end
        end
        S_READ: begin
          if (bus.trace_rd_valid) begin
            rd_req_q <= 1'b0;
            opcode_q <= bus.trace_rd_data[AW+6:AW];
            line_q   <= rd_line;
            state    <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (!is_mem) begin
            head   <= head_nxt;
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (!trk_occ[cur_set]) begin
            state     <= S_MAKE_REQ;
            pf_req_q  <= 1'b1;
            pf_addr_q <= line_q;
          end else if (trk_line[cur_set] == line_q) begin
            // Same line already tracked: hand ownership to this entry, no new request.
            trk_idx[cur_set] <= head;
            head   <= head_nxt;
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            state <= S_BLOCKED;
          end
        end
        S_BLOCKED: begin
          if (!trk_occ[cur_set]) begin
            state     <= S_MAKE_REQ;
            pf_req_q  <= 1'b1;
            pf_addr_q <= line_q;
          end
        end
        S_MAKE_REQ: begin
          if (bus.pf_gnt) begin
            trk_occ[cur_set]  <= 1'b1;
            trk_line[cur_set] <= line_q;
            trk_proc[cur_set] <= 1'b1;
            trk_idx[cur_set]  <= head;
            head     <= head_nxt;
            pf_req_q <= 1'b0;
            state    <= S_IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          rd_req_q <= 1'b0;
          pf_req_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dm_prefetch_scheduler.sv
module tb_dm_prefetch_scheduler;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_ADD = 7'h33;

  logic clk;
  logic rst_a_n, rst_b_n, rst_c_n;
  logic gnt_auto_a, gnt_auto_b, gnt_auto_c;
  int   passed, total;

  logic [63:0] mem_a [64];
  logic [63:0] mem_b [16];
  logic [63:0] mem_c [16];
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] q_c[$];

  // a: default parameters; b: small index space with LOOKAHEAD=2; c: small index space for wrap
  dm_prefetch_scheduler_if ia ();
  dm_prefetch_scheduler_if #(.TRACE_ENTRIES(16)) ib ();
  dm_prefetch_scheduler_if #(.TRACE_ENTRIES(16)) ic ();

  dm_prefetch_scheduler dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ia));
  dm_prefetch_scheduler #(.TRACE_ENTRIES(16), .LOOKAHEAD(2)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ib));
  dm_prefetch_scheduler #(.TRACE_ENTRIES(16), .LOOKAHEAD(15)) dut_c (.clk(clk), .rst_n(rst_c_n), .bus(ic));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] ent(input logic [6:0] op, input logic [31:0] a);
    return {25'h0, op, a};
  endfunction

  // Trace repository and cache grant responders
  initial forever begin
    @(negedge clk);
    if (ia.trace_rd_valid) ia.trace_rd_valid = 1'b0;
    else if (ia.trace_rd_req) begin
      ia.trace_rd_valid = 1'b1;
      ia.trace_rd_data  = mem_a[ia.trace_rd_index[5:0]];
    end
    ia.pf_gnt = gnt_auto_a && ia.pf_req;
  end
  initial forever begin
    @(negedge clk);
    if (ib.trace_rd_valid) ib.trace_rd_valid = 1'b0;
    else if (ib.trace_rd_req) begin
      ib.trace_rd_valid = 1'b1;
      ib.trace_rd_data  = mem_b[ib.trace_rd_index];
    end
    ib.pf_gnt = gnt_auto_b && ib.pf_req;
  end
  initial forever begin
    @(negedge clk);
    if (ic.trace_rd_valid) ic.trace_rd_valid = 1'b0;
    else if (ic.trace_rd_req) begin
      ic.trace_rd_valid = 1'b1;
      ic.trace_rd_data  = mem_c[ic.trace_rd_index];
    end
    ic.pf_gnt = gnt_auto_c && ic.pf_req;
  end

  // Log every accepted prefetch
  always @(posedge clk) if (ia.pf_req && ia.pf_gnt) q_a.push_back(ia.pf_addr);
  always @(posedge clk) if (ib.pf_req && ib.pf_gnt) q_b.push_back(ib.pf_addr);
  always @(posedge clk) if (ic.pf_req && ic.pf_gnt) q_c.push_back(ic.pf_addr);

  task automatic retire_a(input logic [15:0] idx, input logic [31:0] addr);
    @(negedge clk);
    ia.retire_valid = 1'b1; ia.retire_index = idx; ia.retire_addr = addr;
    @(negedge clk);
    ia.retire_valid = 1'b0;
  endtask
  task automatic retire_b(input logic [3:0] idx, input logic [31:0] addr);
    @(negedge clk);
    ib.retire_valid = 1'b1; ib.retire_index = idx; ib.retire_addr = addr;
    @(negedge clk);
    ib.retire_valid = 1'b0;
  endtask
  task automatic retire_c(input logic [3:0] idx, input logic [31:0] addr);
    @(negedge clk);
    ic.retire_valid = 1'b1; ic.retire_index = idx; ic.retire_addr = addr;
    @(negedge clk);
    ic.retire_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++; if (ia.pf_req !== 1'b0) $display("FAIL reset_pf_req got %b exp 0", ia.pf_req); else passed++;
    total++; if (ia.trace_rd_req !== 1'b0) $display("FAIL reset_rd_req got %b exp 0", ia.trace_rd_req); else passed++;
    total++; if (ia.head_index !== 16'd0) $display("FAIL reset_head got %0d exp 0", ia.head_index); else passed++;
    total++; if (ia.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", ia.busy); else passed++;
    total++; if (ia.pf_addr !== 32'h0) $display("FAIL reset_pf_addr got %h exp 0", ia.pf_addr); else passed++;
    total++; if (ia.trace_rd_index !== 16'd0) $display("FAIL reset_rd_index got %0d exp 0", ia.trace_rd_index); else passed++;
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ia.busy !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", ia.busy); else passed++;
  endtask

  task automatic test_basic;
    mem_a[0] = ent(OP_LW, 32'h1000);
    mem_a[1] = ent(OP_ADD, 32'h0);
    mem_a[2] = ent(OP_SW, 32'h2014);
    ia.trace_wr_ptr = 16'd3;
    @(negedge clk);
    for (int i = 0; i < 100 && !(ia.head_index == 16'd3 && !ia.busy); i++) @(negedge clk);
    total++; if (q_a.size() != 2) $display("FAIL basic_count got %0d exp 2", q_a.size()); else passed++;
    total++; if (((q_a.size() > 0) ? q_a[0] : 32'hx) !== 32'h1000) $display("FAIL basic_addr0 got %h exp 1000", (q_a.size() > 0) ? q_a[0] : 32'hx); else passed++;
    total++; if (((q_a.size() > 1) ? q_a[1] : 32'hx) !== 32'h2010) $display("FAIL basic_addr1 got %h exp 2010", (q_a.size() > 1) ? q_a[1] : 32'hx); else passed++;
    total++; if (ia.head_index !== 16'd3) $display("FAIL basic_head got %0d exp 3", ia.head_index); else passed++;
    total++; if (ia.busy !== 1'b0) $display("FAIL basic_busy got %b exp 0", ia.busy); else passed++;
    retire_a(16'd0, 32'h1000);
    retire_a(16'd2, 32'h2014);
  endtask

  task automatic test_merge_and_block;
    int seen;
    mem_a[3] = ent(OP_LW, 32'h1000);
    mem_a[4] = ent(OP_LW, 32'h1008);
    ia.trace_wr_ptr = 16'd5;
    @(negedge clk);
    for (int i = 0; i < 100 && !(ia.head_index == 16'd5 && !ia.busy); i++) @(negedge clk);
    total++; if (q_a.size() != 3) $display("FAIL merge_count got %0d exp 3", q_a.size()); else passed++;
    total++; if (((q_a.size() > 2) ? q_a[2] : 32'hx) !== 32'h1000) $display("FAIL merge_addr got %h exp 1000", (q_a.size() > 2) ? q_a[2] : 32'hx); else passed++;
    total++; if (ia.head_index !== 16'd5) $display("FAIL merge_head got %0d exp 5", ia.head_index); else passed++;
    // Retiring the older owner must not free the set; the merged entry now owns it.
    retire_a(16'd3, 32'h1000);
    mem_a[5] = ent(OP_LW, 32'h1400);
    ia.trace_wr_ptr = 16'd6;
    repeat (15) @(negedge clk);
    total++; if (q_a.size() != 3) $display("FAIL block_no_req got %0d grants exp 3", q_a.size()); else passed++;
    total++; if (ia.busy !== 1'b1) $display("FAIL block_busy got %b exp 1", ia.busy); else passed++;
    total++; if (ia.pf_req !== 1'b0) $display("FAIL block_pf_req got %b exp 0", ia.pf_req); else passed++;
    retire_a(16'd4, 32'h1008);
    seen = 0;
    for (int i = 0; i < 2 && seen == 0; i++) begin
      @(negedge clk);
      if (ia.pf_req) seen = 1;
    end
    total++; if (seen != 1) $display("FAIL release_latency pf_req seen %0d exp 1", seen); else passed++;
    for (int i = 0; i < 20 && !(ia.head_index == 16'd6 && !ia.busy); i++) @(negedge clk);
    total++; if (((q_a.size() > 3) ? q_a[3] : 32'hx) !== 32'h1400) $display("FAIL release_addr got %h exp 1400", (q_a.size() > 3) ? q_a[3] : 32'hx); else passed++;
  endtask

  task automatic test_gnt_hold;
    gnt_auto_a = 1'b0;
    mem_a[6] = ent(OP_SW, 32'h2020);
    ia.trace_wr_ptr = 16'd7;
    for (int i = 0; i < 30 && !ia.pf_req; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (ia.pf_req !== 1'b1) $display("FAIL hold_req cycle %0d got %b exp 1", i, ia.pf_req); else passed++;
      total++; if (ia.pf_addr !== 32'h2020) $display("FAIL hold_addr cycle %0d got %h exp 2020", i, ia.pf_addr); else passed++;
    end
    gnt_auto_a = 1'b1;
    for (int i = 0; i < 20 && !(ia.head_index == 16'd7 && !ia.busy); i++) @(negedge clk);
    total++; if (q_a.size() != 5) $display("FAIL hold_count got %0d exp 5", q_a.size()); else passed++;
    total++; if (ia.head_index !== 16'd7) $display("FAIL hold_head got %0d exp 7", ia.head_index); else passed++;
  endtask

  task automatic test_done_and_retire;
    @(negedge clk);
    ia.pf_done = 1'b1; ia.pf_done_set = 6'd2;
    ia.retire_valid = 1'b1; ia.retire_index = 16'd6; ia.retire_addr = 32'h2020;
    @(negedge clk);
    ia.pf_done = 1'b0; ia.retire_valid = 1'b0;
    // A conflicting line in set 2 must now issue without blocking.
    mem_a[7] = ent(OP_LW, 32'h3020);
    ia.trace_wr_ptr = 16'd8;
    for (int i = 0; i < 30 && !(ia.head_index == 16'd8 && !ia.busy); i++) @(negedge clk);
    total++; if (q_a.size() != 6) $display("FAIL done_retire_count got %0d exp 6", q_a.size()); else passed++;
    total++; if (((q_a.size() > 5) ? q_a[5] : 32'hx) !== 32'h3020) $display("FAIL done_retire_addr got %h exp 3020", (q_a.size() > 5) ? q_a[5] : 32'hx); else passed++;
  endtask

  task automatic test_done_keeps_entry;
    @(negedge clk);
    ia.pf_done = 1'b1; ia.pf_done_set = 6'd0;
    @(negedge clk);
    ia.pf_done = 1'b0;
    mem_a[8] = ent(OP_LW, 32'h1800);
    ia.trace_wr_ptr = 16'd9;
    repeat (15) @(negedge clk);
    total++; if (q_a.size() != 6) $display("FAIL done_keeps_count got %0d exp 6", q_a.size()); else passed++;
    total++; if (ia.busy !== 1'b1) $display("FAIL done_keeps_busy got %b exp 1", ia.busy); else passed++;
    retire_a(16'd5, 32'h1400);
    for (int i = 0; i < 20 && !(ia.head_index == 16'd9 && !ia.busy); i++) @(negedge clk);
    total++; if (((q_a.size() > 6) ? q_a[6] : 32'hx) !== 32'h1800) $display("FAIL done_keeps_addr got %h exp 1800", (q_a.size() > 6) ? q_a[6] : 32'hx); else passed++;
    total++; if (ia.head_index !== 16'd9) $display("FAIL done_keeps_head got %0d exp 9", ia.head_index); else passed++;
  endtask

  task automatic test_lookahead;
    for (int i = 0; i < 10; i++) mem_b[i] = ent(OP_LW, 32'(i * 16));
    ib.trace_wr_ptr = 4'd10;
    repeat (40) @(negedge clk);
    total++; if (q_b.size() != 2) $display("FAIL look_count got %0d exp 2", q_b.size()); else passed++;
    total++; if (ib.head_index !== 4'd2) $display("FAIL look_head got %0d exp 2", ib.head_index); else passed++;
    total++; if (ib.busy !== 1'b0) $display("FAIL look_busy got %b exp 0", ib.busy); else passed++;
    retire_b(4'd0, 32'h0);
    repeat (30) @(negedge clk);
    total++; if (q_b.size() != 3) $display("FAIL look_third_count got %0d exp 3", q_b.size()); else passed++;
    total++; if (((q_b.size() > 2) ? q_b[2] : 32'hx) !== 32'h20) $display("FAIL look_third_addr got %h exp 20", (q_b.size() > 2) ? q_b[2] : 32'hx); else passed++;
    total++; if (ib.head_index !== 4'd3) $display("FAIL look_third_head got %0d exp 3", ib.head_index); else passed++;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 15; i++) mem_c[i] = ent(OP_ADD, 32'h0);
    mem_c[15] = ent(OP_LW, 32'h1000);
    ic.trace_wr_ptr = 4'd15;
    @(negedge clk);
    for (int i = 0; i < 200 && !(ic.head_index == 4'd15 && !ic.busy); i++) @(negedge clk);
    total++; if (ic.head_index !== 4'd15) $display("FAIL wrap_pre_head got %0d exp 15", ic.head_index); else passed++;
    mem_c[0] = ent(OP_LW, 32'h2010);
    retire_c(4'd14, 32'h0);
    ic.trace_wr_ptr = 4'd1;
    @(negedge clk);
    for (int i = 0; i < 60 && !(ic.head_index == 4'd1 && !ic.busy); i++) @(negedge clk);
    total++; if (q_c.size() != 2) $display("FAIL wrap_count got %0d exp 2", q_c.size()); else passed++;
    total++; if (((q_c.size() > 0) ? q_c[0] : 32'hx) !== 32'h1000) $display("FAIL wrap_addr0 got %h exp 1000", (q_c.size() > 0) ? q_c[0] : 32'hx); else passed++;
    total++; if (((q_c.size() > 1) ? q_c[1] : 32'hx) !== 32'h2010) $display("FAIL wrap_addr1 got %h exp 2010", (q_c.size() > 1) ? q_c[1] : 32'hx); else passed++;
    total++; if (ic.head_index !== 4'd1) $display("FAIL wrap_head got %0d exp 1", ic.head_index); else passed++;
  endtask

  task automatic test_reset_mid_request;
    mem_c[1] = ent(OP_LW, 32'h3040);
    gnt_auto_c = 1'b0;
    ic.trace_wr_ptr = 4'd2;
    for (int i = 0; i < 30 && !ic.pf_req; i++) @(negedge clk);
    total++; if (ic.pf_req !== 1'b1) $display("FAIL midrst_pre_req got %b exp 1", ic.pf_req); else passed++;
    rst_c_n = 1'b0;
    #1;
    total++; if (ic.pf_req !== 1'b0) $display("FAIL midrst_pf_req got %b exp 0", ic.pf_req); else passed++;
    total++; if (ic.head_index !== 4'd0) $display("FAIL midrst_head got %0d exp 0", ic.head_index); else passed++;
    total++; if (ic.busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", ic.busy); else passed++;
    total++; if (ic.pf_addr !== 32'h0) $display("FAIL midrst_pf_addr got %h exp 0", ic.pf_addr); else passed++;
    ic.trace_wr_ptr = 4'd0;
    @(negedge clk);
    rst_c_n = 1'b1;
    gnt_auto_c = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (ic.busy !== 1'b0) $display("FAIL midrst_after_busy got %b exp 0", ic.busy); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    gnt_auto_a = 1'b1; gnt_auto_b = 1'b1; gnt_auto_c = 1'b1;
    for (int i = 0; i < 64; i++) mem_a[i] = 64'h0;
    for (int i = 0; i < 16; i++) begin mem_b[i] = 64'h0; mem_c[i] = 64'h0; end
    ia.trace_wr_ptr = '0; ia.trace_rd_valid = 1'b0; ia.trace_rd_data = '0; ia.pf_gnt = 1'b0;
    ia.pf_done = 1'b0; ia.pf_done_set = '0; ia.retire_valid = 1'b0; ia.retire_index = '0; ia.retire_addr = '0;
    ib.trace_wr_ptr = '0; ib.trace_rd_valid = 1'b0; ib.trace_rd_data = '0; ib.pf_gnt = 1'b0;
    ib.pf_done = 1'b0; ib.pf_done_set = '0; ib.retire_valid = 1'b0; ib.retire_index = '0; ib.retire_addr = '0;
    ic.trace_wr_ptr = '0; ic.trace_rd_valid = 1'b0; ic.trace_rd_data = '0; ic.pf_gnt = 1'b0;
    ic.pf_done = 1'b0; ic.pf_done_set = '0; ic.retire_valid = 1'b0; ic.retire_index = '0; ic.retire_addr = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_basic;
    test_merge_and_block;
    test_gnt_hold;
    test_done_and_retire;
    test_done_keeps_entry;
    test_lookahead;
    test_wrap;
    test_reset_mid_request;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
